// File: rtl/imm_decomposer_if.sv
// -----------------------------------------------------------------------------
// imm_decomposer_if
//
// Handshake bundle for imm_decomposer. It carries both the upstream value
// channel and the downstream immediate-beat channel.
//
//   in_valid  / in_ready / in_data   : 64-bit value offered by the front end
//   out_valid / out_ready            : beat handshake towards instruction builder
//   out_imm                          : CHUNK_W-bit immediate for this beat
//   out_shift                        : chunk index (shift = CHUNK_W * out_shift)
//   out_keep                         : 0 = MOVZ (first beat), 1 = MOVK
//   out_last                         : final beat of the current value
//
// Modports:
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : imm_decomposer side
// -----------------------------------------------------------------------------
interface imm_decomposer_if #(
  parameter int DATA_W  = 64,
  parameter int CHUNK_W = 16
);
  localparam int NCH = DATA_W / CHUNK_W;
  localparam int SW  = (NCH > 1) ? $clog2(NCH) : 1;

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [CHUNK_W-1:0] out_imm;
  logic [SW-1:0]      out_shift;
  logic               out_keep;
  logic               out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_imm, out_shift, out_keep, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_imm, out_shift, out_keep, out_last
  );
endinterface

// File: rtl/imm_decomposer.sv
// -----------------------------------------------------------------------------
// imm_decomposer
//
// Sequential constant-materialisation unit. Accepts one DATA_W-bit value and
// emits it as CHUNK_W-bit wide-immediate beats: one MOVZ followed by MOVKs,
// each tagged with its chunk index, always in ascending chunk order.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : imm_decomposer_if.slave (value input + beat output handshakes)
//   busy   : high while a value is being emitted
//
// Configuration:
//   IMM_DECOMP_ZERO_SKIP_EN defined   : zero chunks are skipped (1..NCH beats);
//                                       an all-zero value still emits a single
//                                       MOVZ #0 on chunk 0.
//   IMM_DECOMP_ZERO_SKIP_EN undefined : every value emits exactly NCH beats,
//                                       chunk 0..NCH-1, zero chunks included.
// -----------------------------------------------------------------------------
module imm_decomposer #(
  parameter int DATA_W  = 64,
  parameter int CHUNK_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  imm_decomposer_if.slave   bus,
  output logic              busy
);
  localparam int NCH = DATA_W / CHUNK_W;
  localparam int SW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [0:0] {IDLE, EMIT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic              first_q;   // next beat is the MOVZ of this value
  logic              accept;
  logic              fire;
  logic [SW-1:0]     idx;       // chunk index of the beat being presented
  logic              last;      // presented beat is the final one

  assign accept = bus.in_valid && bus.in_ready;
  assign fire   = bus.out_valid && bus.out_ready;

`ifdef IMM_DECOMP_ZERO_SKIP_EN
  logic [NCH-1:0] pend_q;    // chunks still to be emitted
  logic [NCH-1:0] in_mask;   // nonzero chunks of the incoming value
  logic [NCH-1:0] pend_clr;  // pending mask after the current beat retires

  // An all-zero value is forced to pend chunk 0 so it still yields one MOVZ #0.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    in_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      in_mask[i] = |bus.in_data[i*CHUNK_W +: CHUNK_W];
    end
    if (in_mask == '0) in_mask[0] = 1'b1;
  end

  // Lowest set bit wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[i]) idx = SW'(i);
    end
    pend_clr = pend_q & ~(NCH'(1) << idx);
    last     = (pend_clr == '0);
  end

  always_ff @(posedge clk) begin
    if (reset)       pend_q <= '0;
    else if (accept) pend_q <= in_mask;
    else if (fire)   pend_q <= pend_clr;
  end
`else
  logic [SW-1:0] cnt_q;

  assign idx  = cnt_q;
  assign last = (cnt_q == SW'(NCH - 1));

  always_ff @(posedge clk) begin
    if (reset)       cnt_q <= '0;
    else if (accept) cnt_q <= '0;
    else if (fire)   cnt_q <= cnt_q + 1'b1;
  end
`endif

  // NOTE: the value register carries no reset; its contents are only visible
  // in EMIT, which can be reached only after a fresh load.
  always_ff @(posedge clk) begin
    if (accept) data_q <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (reset)       first_q <= 1'b0;
    else if (accept) first_q <= 1'b1;
    else if (fire)   first_q <= 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)       state_d = EMIT;
      EMIT:    if (fire && last) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Output logic: driven purely from registered state, zeroed outside EMIT.
  // in_ready is also gated by reset so it stays low while reset is held.
  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !reset;
    busy          = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_imm   = '0;
    bus.out_shift = '0;
    bus.out_keep  = 1'b0;
    bus.out_last  = 1'b0;
    if (state_q == EMIT) begin
      busy          = 1'b1;
      bus.out_valid = 1'b1;
      bus.out_imm   = data_q[idx*CHUNK_W +: CHUNK_W];
      bus.out_shift = idx;
      bus.out_keep  = !first_q;
      bus.out_last  = last;
    end
  end
endmodule

// File: tb/tb_imm_decomposer.sv
// -----------------------------------------------------------------------------
// tb_imm_decomposer
//
// Directed bench for imm_decomposer at DATA_W=64, CHUNK_W=16. Expected beats
// are written out by hand for both IMM_DECOMP_ZERO_SKIP_EN settings.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_imm_decomposer;
  logic clk;
  logic reset;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  imm_decomposer_if #(.DATA_W(64), .CHUNK_W(16)) bus ();

  imm_decomposer #(.DATA_W(64), .CHUNK_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [15:0] imm, input logic [1:0] sh,
                            input logic keep, input logic last);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd1);
    check({tag, ".imm"}, 64'(bus.out_imm), 64'(imm));
    check({tag, ".shift"}, 64'(bus.out_shift), 64'(sh));
    check({tag, ".keep"}, 64'(bus.out_keep), 64'(keep));
    check({tag, ".last"}, 64'(bus.out_last), 64'(last));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, ".busy"}, 64'(busy), 64'd0);
  endtask

  // Offer a value for exactly one accepting edge, then drive junk that must be ignored.
  task automatic send(input logic [63:0] data);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 64'hDEAD_BEEF_CAFE_F00D;
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst.valid", 64'(bus.out_valid), 64'd0);
    check("rst.in_ready", 64'(bus.in_ready), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.imm", 64'(bus.out_imm), 64'd0);
    check("rst.shift", 64'(bus.out_shift), 64'd0);
    check("rst.keep", 64'(bus.out_keep), 64'd0);
    check("rst.last", 64'(bus.out_last), 64'd0);
    reset = 1'b0;
    tick();
    check_idle("idle0");
    tick();
    check_idle("idle1");  // out_ready high with no beat pending has no effect

    // 0x0ABC
    send(64'h0000_0000_0000_0ABC);
`ifdef IMM_DECOMP_ZERO_SKIP_EN
    check_beat("a0", 16'h0ABC, 2'd0, 1'b0, 1'b1);
`else
    check_beat("a0", 16'h0ABC, 2'd0, 1'b0, 1'b0);
    tick(); check_beat("a1", 16'h0000, 2'd1, 1'b1, 1'b0);
    tick(); check_beat("a2", 16'h0000, 2'd2, 1'b1, 1'b0);
    tick(); check_beat("a3", 16'h0000, 2'd3, 1'b1, 1'b1);
`endif
    tick();
    check_idle("a_done");

    // All ones with a 3-cycle stall on the beat at shift 2
    send(64'hFFFF_FFFF_FFFF_FFFF);
    check_beat("f0", 16'hFFFF, 2'd0, 1'b0, 1'b0);
    tick(); check_beat("f1", 16'hFFFF, 2'd1, 1'b1, 1'b0);
    tick(); check_beat("f2", 16'hFFFF, 2'd2, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check_beat("f2_stall", 16'hFFFF, 2'd2, 1'b1, 1'b0);
    end
    bus.out_ready = 1'b1;
    tick(); check_beat("f3", 16'hFFFF, 2'd3, 1'b1, 1'b1);
    // Next value offered during the last beat must not be taken on that edge
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h1234_0000_5678_0000;
    tick();
    check_idle("f_done");
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 64'hDEAD_BEEF_CAFE_F00D;

    // 0x1234_0000_5678_0000 (accepted back-to-back above)
`ifdef IMM_DECOMP_ZERO_SKIP_EN
    check_beat("b0", 16'h5678, 2'd1, 1'b0, 1'b0);
    tick(); check_beat("b1", 16'h1234, 2'd3, 1'b1, 1'b1);
`else
    check_beat("b0", 16'h0000, 2'd0, 1'b0, 1'b0);
    tick(); check_beat("b1", 16'h5678, 2'd1, 1'b1, 1'b0);
    tick(); check_beat("b2", 16'h0000, 2'd2, 1'b1, 1'b0);
    tick(); check_beat("b3", 16'h1234, 2'd3, 1'b1, 1'b1);
`endif
    tick();
    check_idle("b_done");

    // Reset after the first beat of 0x1234_0000_5678_0000 is accepted
    send(64'h1234_0000_5678_0000);
`ifdef IMM_DECOMP_ZERO_SKIP_EN
    check_beat("r0", 16'h5678, 2'd1, 1'b0, 1'b0);
`else
    check_beat("r0", 16'h0000, 2'd0, 1'b0, 1'b0);
`endif
    tick();
    reset = 1'b1;
    tick();
    check("rmid.valid", 64'(bus.out_valid), 64'd0);
    check("rmid.in_ready", 64'(bus.in_ready), 64'd0);
    check("rmid.busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();
    check_idle("rmid_after");
    for (int i = 0; i < 3; i++) begin
      tick(); check_idle("rmid_quiet");
    end

    // All-zero value
    send(64'h0);
`ifdef IMM_DECOMP_ZERO_SKIP_EN
    check_beat("z0", 16'h0000, 2'd0, 1'b0, 1'b1);
`else
    check_beat("z0", 16'h0000, 2'd0, 1'b0, 1'b0);
    tick(); check_beat("z1", 16'h0000, 2'd1, 1'b1, 1'b0);
    tick(); check_beat("z2", 16'h0000, 2'd2, 1'b1, 1'b0);
    tick(); check_beat("z3", 16'h0000, 2'd3, 1'b1, 1'b1);
`endif
    tick();
    check_idle("z_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
